// File: rtl/key_event_pkg.sv
// Shared constants for the key event decoder: FSM encoding, counter widths,
// default 1 ms prescaler terminal count and the registered event bundle.
package key_event_pkg;

    localparam int PRESC_W = 16;
    localparam int MS_W    = 12;

    localparam logic [PRESC_W-1:0] T1MS_DEFAULT = 16'd49_999;
    localparam logic [MS_W-1:0]    MS_MAX       = {MS_W{1'b1}};

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESSED = 2'd1;
    localparam logic [1:0] ST_LONG    = 2'd2;

    typedef struct packed {
        logic press;
        logic rel;
        logic shrt;
        logic lng;
        logic rpt;
    } key_events_t;

    // The ms counter must hold at full scale rather than wrap back to zero.
    function automatic logic [MS_W-1:0] ms_sat_inc(input logic [MS_W-1:0] v);
        return (v == MS_MAX) ? v : v + MS_W'(1);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// 1 ms time base: counts 0..T1MS while enabled and pulses tick on the wrap.
// Held at zero while disabled or cleared.
module ms_tick_gen
    import key_event_pkg::*;
#(
    parameter logic [PRESC_W-1:0] T1MS = T1MS_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        presc_d = presc_q;
        tick    = 1'b0;
        if (clr || !en) begin
            presc_d = '0;
        end else if (presc_q == T1MS) begin
            presc_d = '0;
            tick    = 1'b1;
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) presc_q <= '0;
        else     presc_q <= presc_d;
    end

endmodule

// File: rtl/key_event_decoder.sv
// Turns a debounced key level into press/release/short/long/repeat pulses.
// Auto-repeat is built only when KEY_REPEAT_EN is defined.
module key_event_decoder
    import key_event_pkg::*;
#(
    parameter logic [PRESC_W-1:0] T1MS      = T1MS_DEFAULT,
    parameter logic [MS_W-1:0]    LONG_MS   = 12'd1000,
    parameter logic [MS_W-1:0]    REPEAT_MS = 12'd200
) (
    input  logic CLK,
    input  logic RST,
    input  logic Key_In,
    output logic Press_Pulse,
    output logic Release_Pulse,
    output logic Short_Pulse,
    output logic Long_Pulse,
    output logic Repeat_Pulse,
    output logic Key_Held
);

`ifdef KEY_REPEAT_EN
    localparam logic REPEAT_EN = 1'b1;
`else
    localparam logic REPEAT_EN = 1'b0;
`endif

    logic              key_q, key_d;
    logic              key_prev_q, key_prev_d;
    logic [1:0]        state_q, state_d;
    logic [MS_W-1:0]   ms_q, ms_d;
    key_events_t       ev_q, ev_d;
    logic              held_q, held_d;
    logic              rise, fall;
    logic              ms_clr;
    logic              tick;
    logic              presc_en;
    logic              rpt_hit;

    // Edges are taken between two registered samples, so an event is issued
    // on the edge after the first one that captured the new key level.
    assign rise    = key_q & ~key_prev_q;
    assign fall    = ~key_q & key_prev_q;
    assign rpt_hit = REPEAT_EN && (ms_q == REPEAT_MS);
    assign presc_en = (state_q != ST_IDLE);

    ms_tick_gen #(.T1MS(T1MS)) u_tick (
        .clk  (CLK),
        .rst  (RST),
        .en   (presc_en),
        .clr  (ev_d.press),
        .tick (tick)
    );

    always_comb begin
        key_d      = Key_In;
        key_prev_d = key_q;
        state_d    = state_q;
        ev_d       = '0;
        ms_clr     = 1'b0;
        // A release always beats a coincident long or repeat match.
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    ev_d.press = 1'b1;
                    state_d    = ST_PRESSED;
                    ms_clr     = 1'b1;
                end
            end
            ST_PRESSED: begin
                if (fall) begin
                    ev_d.rel  = 1'b1;
                    ev_d.shrt = 1'b1;
                    state_d   = ST_IDLE;
                    ms_clr    = 1'b1;
                end else if (ms_q == LONG_MS) begin
                    ev_d.lng = 1'b1;
                    state_d  = ST_LONG;
                    ms_clr   = 1'b1;
                end
            end
            ST_LONG: begin
                if (fall) begin
                    ev_d.rel = 1'b1;
                    state_d  = ST_IDLE;
                    ms_clr   = 1'b1;
                end else if (rpt_hit) begin
                    ev_d.rpt = 1'b1;
                    ms_clr   = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ms_clr  = 1'b1;
            end
        endcase
        held_d = (state_d != ST_IDLE);
    end

    always_comb begin
        ms_d = ms_q;
        if (ms_clr)    ms_d = '0;
        else if (tick) ms_d = ms_sat_inc(ms_q);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            key_q      <= 1'b0;
            key_prev_q <= 1'b0;
            state_q    <= ST_IDLE;
            ms_q       <= '0;
            ev_q       <= '0;
            held_q     <= 1'b0;
        end else begin
            key_q      <= key_d;
            key_prev_q <= key_prev_d;
            state_q    <= state_d;
            ms_q       <= ms_d;
            ev_q       <= ev_d;
            held_q     <= held_d;
        end
    end

    assign Press_Pulse   = ev_q.press;
    assign Release_Pulse = ev_q.rel;
    assign Short_Pulse   = ev_q.shrt;
    assign Long_Pulse    = ev_q.lng;
    assign Repeat_Pulse  = ev_q.rpt;
    assign Key_Held      = held_q;

endmodule
